// File: rtl/bl_mux_scheduler_if.sv
// Signal bundle between the requesting engines, the scheduler and the BL_MUX
// select/enable pins. master = scheduler side, slave = requesters/MUX side.
interface bl_mux_scheduler_if;
   logic [7:0] req;
   logic       A2_out;
   logic       A1_out;
   logic       A0_out;
   logic       EN_out;
   logic [7:0] grant;
   logic       busy;
   logic       done;
   logic [1:0] dbg_state;

   modport master (
      input  req,
      output A2_out, A1_out, A0_out, EN_out, grant, busy, done, dbg_state
   );

   modport slave (
      output req,
      input  A2_out, A1_out, A0_out, EN_out, grant, busy, done, dbg_state
   );
endinterface

// File: rtl/bl_mux_scheduler.sv
// Round-robin scheduler for the shared bit-line MUX: picks one of 8 requesters,
// drives A2..A0 and EN with break-before-make sequencing SETUP->ACTIVE->GUARD.
module bl_mux_scheduler #(
   parameter int unsigned DWELL     = 4,
   parameter int unsigned GUARD_CYC = 1
) (
   input logic                 Clk,
   input logic                 Reset,
   bl_mux_scheduler_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACTIVE = 2'd2,
      GUARD  = 2'd3
   } state_t;

   state_t     state;
   logic [2:0] rr_ptr;
   logic [2:0] addr;
   logic [7:0] cnt;
   logic [7:0] grant;
   logic       en;
   logic       busy;
   logic       done;

   logic [2:0] pick;
   logic [2:0] idx;
   logic       pick_valid;

   // Descending scan so the requester closest to rr_ptr is written last and wins.
   always_comb begin
      pick       = '0;
      idx        = '0;
      pick_valid = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         idx = rr_ptr + 3'(i);
         if (bus.req[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= IDLE;
         rr_ptr <= '0;
         addr   <= '0;
         cnt    <= '0;
         grant  <= '0;
         en     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  addr  <= pick;
                  grant <= 8'd1 << pick;
                  busy  <= 1'b1;
                  state <= SETUP;
               end
            end
            SETUP: begin
               state <= ACTIVE;
               en    <= 1'b1;
               cnt   <= 8'(DWELL - 1);
               done  <= (DWELL == 1);
            end
            ACTIVE: begin
               // Dropped request and expired dwell both leave through GUARD so
               // EN is low before the address can move.
               if (!bus.req[addr] || cnt == 8'd0) begin
                  state <= GUARD;
                  en    <= 1'b0;
                  cnt   <= 8'(GUARD_CYC - 1);
               end else begin
                  cnt  <= cnt - 8'd1;
                  done <= (cnt == 8'd1);
               end
            end
            GUARD: begin
               if (cnt == 8'd0) begin
                  state  <= IDLE;
                  grant  <= '0;
                  busy   <= 1'b0;
                  rr_ptr <= addr + 3'd1;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.A2_out    = addr[2];
   assign bus.A1_out    = addr[1];
   assign bus.A0_out    = addr[0];
   assign bus.EN_out    = en;
   assign bus.grant     = grant;
   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.dbg_state = state;

endmodule

// File: tb/tb_bl_mux_scheduler.sv
// Bench for bl_mux_scheduler: vector table, directed corner sequences and
// randomized traffic compared against a grant-timeline reference model.
module tb_bl_mux_scheduler;

   logic clk;
   logic rst4;
   logic rst1;

   bl_mux_scheduler_if if4 ();
   bl_mux_scheduler_if if1 ();

   bl_mux_scheduler #(.DWELL(4), .GUARD_CYC(1)) dut4 (
      .Clk(clk), .Reset(rst4), .bus(if4)
   );
   bl_mux_scheduler #(.DWELL(1), .GUARD_CYC(2)) dut1 (
      .Clk(clk), .Reset(rst1), .bus(if1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: a grant is a timeline of offsets t from its SETUP cycle.
   // t=0 SETUP, 1..gstart-1 EN high, then gd guard cycles, then idle.
   typedef struct {
      bit         in_g;
      logic [2:0] win;
      logic [2:0] ptr;
      logic [2:0] last_a;
      int         t;
      int         gstart;
      bit         aborted;
   } mdl_t;

   mdl_t m4, m1;

   function automatic mdl_t mstep(mdl_t s, logic rst, logic [7:0] rq, int dw, int gd);
      mdl_t r = s;
      if (rst) begin
         r = '{default: '0};
      end else if (!r.in_g) begin
         if (rq != 8'h00) begin
            for (int k = 7; k >= 0; k--) begin
               int c = (int'(r.ptr) + k) % 8;
               if (rq[c]) r.win = 3'(c);
            end
            r.last_a  = r.win;
            r.in_g    = 1'b1;
            r.t       = 0;
            r.gstart  = dw + 1;
            r.aborted = 1'b0;
         end
      end else begin
         if (r.t >= 1 && r.t < dw && r.t < r.gstart && !rq[r.win]) begin
            r.gstart  = r.t + 1;
            r.aborted = 1'b1;
         end
         r.t++;
         if (r.t == r.gstart + gd) begin
            r.in_g = 1'b0;
            r.ptr  = 3'((int'(r.win) + 1) % 8);
         end
      end
      return r;
   endfunction

   // Packing: {busy, done, EN, A[2:0], grant[7:0]}
   function automatic logic [13:0] mexp(mdl_t s, int dw);
      logic en_e, done_e;
      if (!s.in_g) return {3'b000, s.last_a, 8'h00};
      en_e   = (s.t >= 1 && s.t < s.gstart);
      done_e = (s.t == dw && !s.aborted);
      return {1'b1, done_e, en_e, s.win, 8'(8'd1 << s.win)};
   endfunction

   function automatic logic [13:0] obs4();
      return {if4.busy, if4.done, if4.EN_out, if4.A2_out, if4.A1_out, if4.A0_out, if4.grant};
   endfunction

   function automatic logic [13:0] obs1();
      return {if1.busy, if1.done, if1.EN_out, if1.A2_out, if1.A1_out, if1.A0_out, if1.grant};
   endfunction

   logic       prev_en1;
   logic [2:0] prev_a1;

   // driver: inputs are set at the negedge before calling tick
   task automatic tick();
      logic [2:0] a1;
      @(posedge clk);
      m4 = mstep(m4, rst4, if4.req, 4, 1);
      m1 = mstep(m1, rst1, if1.req, 1, 2);
      @(negedge clk);
      check("model_dut4", 32'(obs4()), 32'(mexp(m4, 4)));
      check("model_dut1", 32'(obs1()), 32'(mexp(m1, 1)));
      a1 = {if1.A2_out, if1.A1_out, if1.A0_out};
      if (prev_en1 && if1.EN_out) check("addr_stable_en", 32'(a1), 32'(prev_a1));
      if (a1 != prev_a1) check("break_before_make", {30'd0, prev_en1, if1.EN_out}, 32'd0);
      prev_en1 = if1.EN_out;
      prev_a1  = a1;
   endtask

   typedef struct {
      logic        rst;
      logic [7:0]  req;
      logic [13:0] exp;
   } vec_t;

   vec_t        tbl[10];
   logic [10:0] exp_q[$];
   logic [10:0] got_q[$];
   int          ch_cnt[8];

   initial begin
      int  grants;
      int  budget;
      bit  found;
      bit  prev_busy;
      bit  saw_idle;
      bit  done_seen;

      tbl[0] = '{1'b1, 8'hFF, {3'b000, 3'b000, 8'h00}};
      tbl[1] = '{1'b1, 8'hFF, {3'b000, 3'b000, 8'h00}};
      tbl[2] = '{1'b0, 8'h20, {3'b100, 3'b101, 8'h20}};
      tbl[3] = '{1'b0, 8'h20, {3'b101, 3'b101, 8'h20}};
      tbl[4] = '{1'b0, 8'h20, {3'b101, 3'b101, 8'h20}};
      tbl[5] = '{1'b0, 8'h20, {3'b101, 3'b101, 8'h20}};
      tbl[6] = '{1'b0, 8'h20, {3'b111, 3'b101, 8'h20}};
      tbl[7] = '{1'b0, 8'h20, {3'b100, 3'b101, 8'h20}};
      tbl[8] = '{1'b0, 8'h20, {3'b000, 3'b101, 8'h00}};
      tbl[9] = '{1'b0, 8'h20, {3'b100, 3'b101, 8'h20}};

      m4 = '{default: '0};
      m1 = '{default: '0};
      prev_en1 = 1'b0;
      prev_a1  = 3'd0;
      rst4 = 1'b1;
      rst1 = 1'b1;
      if4.req = 8'hFF;
      if1.req = 8'hFF;
      @(negedge clk);

      // reset values and single-channel dwell timeline
      for (int i = 0; i < 10; i++) begin
         rst4    = tbl[i].rst;
         if4.req = tbl[i].req;
         tick();
         check($sformatf("vec[%0d]", i), 32'(obs4()), 32'(tbl[i].exp));
      end

      // round-robin wrap: ch0, ch2, ch7, ch0
      rst4 = 1'b1; tick(); rst4 = 1'b0;
      if4.req = 8'b1000_0101;
      exp_q = '{{3'd0, 8'h01}, {3'd2, 8'h04}, {3'd7, 8'h80}, {3'd0, 8'h01}};
      got_q = {};
      prev_busy = 1'b0;
      budget = 0;
      while (got_q.size() < 4 && budget < 100) begin
         tick();
         budget++;
         if (if4.busy && !prev_busy)
            got_q.push_back({if4.A2_out, if4.A1_out, if4.A0_out, if4.grant});
         prev_busy = if4.busy;
      end
      check("rr_grant_count", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++)
         check($sformatf("rr_grant[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));

      // abort in second ACTIVE cycle, then wrap via rr_ptr=4
      rst4 = 1'b1; tick(); rst4 = 1'b0;
      if4.req = 8'h08;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (if4.EN_out) found = 1'b1;
      end
      check("abort_en_seen", 32'(found), 32'd1);
      done_seen = if4.done;
      tick();
      done_seen |= if4.done;
      if4.req = 8'h00;
      tick();
      check("abort_en_low", 32'(if4.EN_out), 32'd0);
      done_seen |= if4.done;
      if4.req = 8'h09;
      found = 1'b0;
      saw_idle = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (!if4.busy) saw_idle = 1'b1;
         else if (saw_idle) found = 1'b1;
         else done_seen |= if4.done;
      end
      check("abort_next_found", 32'(found), 32'd1);
      check("abort_wrap_grant", 32'(if4.grant), 32'h01);
      check("abort_no_done", 32'(done_seen), 32'd0);

      // reset during ACTIVE of ch7 clears rr_ptr
      rst4 = 1'b1; tick(); rst4 = 1'b0;
      if4.req = 8'h81;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         tick();
         if (if4.EN_out && if4.grant == 8'h80) found = 1'b1;
      end
      check("rst_ch7_active", 32'(found), 32'd1);
      rst4 = 1'b1;
      tick();
      check("rst_en", 32'(if4.EN_out), 32'd0);
      check("rst_busy", 32'(if4.busy), 32'd0);
      check("rst_done", 32'(if4.done), 32'd0);
      rst4 = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (if4.busy) found = 1'b1;
      end
      check("rst_next_found", 32'(found), 32'd1);
      check("rst_next_grant", 32'(if4.grant), 32'h01);

      // randomized traffic with occasional resets
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 3) == 0) if4.req = 8'($urandom);
         rst4 = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst4 = 1'b0;

      // DWELL=1 fairness run, all channels requesting
      rst1 = 1'b1; tick(); rst1 = 1'b0;
      if1.req = 8'hFF;
      foreach (ch_cnt[i]) ch_cnt[i] = 0;
      grants = 0;
      prev_busy = 1'b0;
      budget = 0;
      while (grants < 64 && budget < 1000) begin
         tick();
         budget++;
         if (if1.busy && !prev_busy) begin
            ch_cnt[{if1.A2_out, if1.A1_out, if1.A0_out}]++;
            grants++;
         end
         prev_busy = if1.busy;
      end
      check("fair_grants", 32'(grants), 32'd64);
      for (int i = 0; i < 8; i++)
         check($sformatf("fair_ch%0d", i), 32'(ch_cnt[i]), 32'd8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
